// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode seven-segment display sharing one BCD decoder.
// A new value is captured into a shadow register by `load` and copied to the
// displayed word only when digit 3 finishes, so a frame never mixes values.
// Each digit slot is BLK_CYC blank cycles followed by DIG_CYC lit cycles.
// Optional feature macro: LZ_SUPPRESS_EN (leading-zero suppression of
// digits 3..1; digit 0 always lit).
module display_scan_ctrl #(
  parameter int DIG_CYC = 50000,
  parameter int BLK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  output logic [3:0]  BCD,
  output logic [3:0]  an,
  output logic        frame,
  output logic        pend
);

  localparam int MAX_CYC = (DIG_CYC > BLK_CYC) ? DIG_CYC : BLK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] BLK_LAST = CW'(BLK_CYC - 1);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIG_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_active;
  logic          r_pend;
  logic [3:0]    r_bcd;
  logic [3:0]    r_an;
  logic          r_frame;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    w_idx_next;
  logic [15:0]   w_shadow_next;
  logic [15:0]   w_active_next;
  logic          w_pend_next;
  logic          w_wrap;
  logic          w_suppress;
  logic [3:0]    w_bcd_next;
  logic [3:0]    w_an_next;

  // State register plus all registered outputs; reset parks the scan at the
  // start of the blank slot for digit 0 with everything dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_BLANK;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= 16'd0;
      r_active <= 16'd0;
      r_pend   <= 1'b0;
      r_bcd    <= 4'd0;
      r_an     <= 4'b1111;
      r_frame  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shadow <= w_shadow_next;
      r_active <= w_active_next;
      r_pend   <= w_pend_next;
      r_bcd    <= w_bcd_next;
      r_an     <= w_an_next;
      r_frame  <= w_wrap;
    end
  end

  // Slot sequencing, digit advance, frame wrap and shadow/active handover.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    w_idx_next   = r_idx;
    w_wrap       = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLK_LAST) begin
          w_state_next = ST_SHOW;
          w_cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DIG_LAST) begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
          w_idx_next   = r_idx + 2'd1;
          w_wrap       = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_next = ST_BLANK;
        w_cnt_next   = '0;
      end
    endcase
    // The wrap copies the shadow as it stood before this edge; a load on the
    // same edge lands in the shadow and remains pending for the next wrap.
    w_active_next = (w_wrap && r_pend) ? r_shadow : r_active;
    w_shadow_next = load ? value : r_shadow;
    w_pend_next   = load ? 1'b1 : (w_wrap ? 1'b0 : r_pend);
  end

`ifdef LZ_SUPPRESS_EN
  // Digit i (i>0) stays dark when it and every digit above it are zero.
  assign w_suppress = (w_idx_next != 2'd0) &&
                      ((w_active_next >> {w_idx_next, 2'b00}) == 16'd0);
`else
  assign w_suppress = 1'b0;
`endif

  // Output decode for the coming cycle: the nibble is pre-driven during blank
  // so the decoder settles before the anode turns on.
  always_comb begin
    w_bcd_next = w_active_next[{w_idx_next, 2'b00} +: 4];
    w_an_next  = 4'b1111;
    if (w_state_next == ST_SHOW && enable && !w_suppress) begin
      w_an_next = ~(4'b0001 << w_idx_next);
    end
  end

  assign BCD   = r_bcd;
  assign an    = r_an;
  assign frame = r_frame;
  assign pend  = r_pend;

endmodule
